// File: rtl/imem_loader.sv
// imem_loader: receives a program frame over a UART byte stream and writes it
// into instruction memory through the IMEM A port, which it shares with the
// core fetch path. Frame: SYNC, N, 4*N little-endian data bytes, XOR checksum.
module imem_loader #(
    parameter int         DEPTH       = 14,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic [31:0] core_pc,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wd,
    output logic        imem_we,
    output logic        core_stall,
    output logic        core_restart,
    output logic        prog_busy,
    output logic        prog_done,
    output logic        prog_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_LEN,
        GET_DATA,
        WRITE,
        GET_CSUM,
        DONE,
        ERR
    } state_t;

    state_t         state, state_d;

    logic [7:0]     n_len;     // word count of the current frame
    logic [7:0]     wr_idx;    // index of the next word to write
    logic [1:0]     byte_idx;  // byte position inside the word being assembled
    logic [23:0]    word;      // low three bytes; the fourth goes straight to imem_wd
    logic [7:0]     csum;
    logic [TW-1:0]  timer;

    // Per-cycle strobes from the FSM into the datapath
    logic start;       // SYNC accepted in IDLE
    logic len_ok;      // valid length byte, latch it
    logic data_byte;   // byte belongs to a data word
    logic word_full;   // fourth byte of a word, write it next cycle
    logic in_frame;    // states where the inter-byte timer runs
    logic byte_in;     // a byte was consumed by the frame
    logic tmo;
    logic last_word;

    assign tmo       = (timer == TW'(TIMEOUT_CYC - 1));
    assign last_word = ((wr_idx + 8'd1) == n_len);
    assign in_frame  = state inside {GET_LEN, GET_DATA, WRITE, GET_CSUM};
    assign byte_in   = rx_valid && in_frame;

    // Core fetches through the same port unless a frame is being loaded
    assign imem_addr = prog_busy ? {22'd0, wr_idx, 2'b00} : core_pc;

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_d;
    end

    // Next state and datapath strobes
    always_comb begin
        state_d   = state;
        start     = 1'b0;
        len_ok    = 1'b0;
        data_byte = 1'b0;
        word_full = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_d = GET_LEN;
                    start   = 1'b1;
                end
            end
            GET_LEN: begin
                if (rx_valid) begin
                    if (rx_data == 8'd0 || rx_data > 8'(DEPTH)) begin
                        state_d = ERR;
                    end else begin
                        state_d = GET_DATA;
                        len_ok  = 1'b1;
                    end
                end else if (tmo) begin
                    state_d = ERR;
                end
            end
            GET_DATA: begin
                if (rx_valid) begin
                    data_byte = 1'b1;
                    if (byte_idx == 2'd3) begin
                        state_d   = WRITE;
                        word_full = 1'b1;
                    end
                end else if (tmo) begin
                    state_d = ERR;
                end
            end
            WRITE: begin
                // A byte landing here is never dropped: it is either the
                // first byte of the next word or, after the last word, the checksum
                if (last_word) begin
                    if (rx_valid) state_d = (rx_data == csum) ? DONE : ERR;
                    else          state_d = GET_CSUM;
                end else begin
                    state_d   = GET_DATA;
                    data_byte = rx_valid;
                end
            end
            GET_CSUM: begin
                if (rx_valid)  state_d = (rx_data == csum) ? DONE : ERR;
                else if (tmo)  state_d = ERR;
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Frame datapath, write port and status flags
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            n_len        <= '0;
            wr_idx       <= '0;
            byte_idx     <= '0;
            word         <= '0;
            csum         <= '0;
            timer        <= '0;
            imem_wd      <= '0;
            imem_we      <= 1'b0;
            core_stall   <= 1'b0;
            core_restart <= 1'b0;
            prog_busy    <= 1'b0;
            prog_done    <= 1'b0;
            prog_err     <= 1'b0;
        end else begin
            imem_we      <= word_full;
            core_restart <= (state_d == DONE);

            if (start || byte_in) timer <= '0;
            else if (in_frame)    timer <= timer + TW'(1);
            else                  timer <= '0;

            if (start) begin
                csum       <= '0;
                byte_idx   <= '0;
                wr_idx     <= '0;
                prog_busy  <= 1'b1;
                core_stall <= 1'b1;
                prog_done  <= 1'b0;
                prog_err   <= 1'b0;
            end

            if (len_ok) n_len <= rx_data;

            if (data_byte) begin
                case (byte_idx)
                    2'd0:    word[7:0]   <= rx_data;
                    2'd1:    word[15:8]  <= rx_data;
                    2'd2:    word[23:16] <= rx_data;
                    default: ;
                endcase
                csum     <= csum ^ rx_data;
                byte_idx <= byte_idx + 2'd1;
            end

            if (word_full) imem_wd <= {rx_data, word};

            if (state == WRITE) wr_idx <= wr_idx + 8'd1;

            if (state == DONE) begin
                prog_done  <= 1'b1;
                prog_busy  <= 1'b0;
                core_stall <= 1'b0;
            end

            // Stall is held after a failure: IMEM may contain a partial image
            if (state == ERR) begin
                prog_err  <= 1'b1;
                prog_busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized frames against a frame-level reference model.
// Expected IMEM writes, restart pulses and error events go into a queue when a
// frame is issued; a negedge monitor pops and compares as the DUT produces them.
module tb_imem_loader;
    localparam int         DEPTH = 14;
    localparam int         TMO   = 48;
    localparam logic [7:0] SYNC  = 8'hA5;
    localparam int EV_WR = 0, EV_RS = 1, EV_ER = 2;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [31:0] core_pc = 32'h0;
    logic [31:0] imem_addr, imem_wd;
    logic        imem_we, core_stall, core_restart, prog_busy, prog_done, prog_err;

    imem_loader #(.DEPTH(DEPTH), .SYNC_BYTE(SYNC), .TIMEOUT_CYC(TMO)) dut (
        .CLK(CLK), .RST_N(RST_N), .rx_valid(rx_valid), .rx_data(rx_data),
        .core_pc(core_pc), .imem_addr(imem_addr), .imem_wd(imem_wd),
        .imem_we(imem_we), .core_stall(core_stall), .core_restart(core_restart),
        .prog_busy(prog_busy), .prog_done(prog_done), .prog_err(prog_err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        int          at;    // expected cycle, -1 = any
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] frm[$];
    int n_chk = 0, n_pass = 0;
    int last_cyc = 0;
    logic m_done = 0, m_err = 0, m_stall = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic push(input int k, input logic [31:0] a, input logic [31:0] d, input int at);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d; e.at = at;
        exp_q.push_back(e);
    endtask

    task automatic mon_pop(input int k, input logic [31:0] a, input logic [31:0] d, input int c);
        ev_t e;
        bit  ok;
        n_chk++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: kind %0d addr %h data %h cycle %0d, nothing expected",
                     k, a, d, c);
        end else begin
            e  = exp_q.pop_front();
            ok = (k == e.kind) && (k != EV_WR || (a == e.addr && d == e.data)) &&
                 (e.at < 0 || c == e.at);
            if (ok) n_pass++;
            else $display("FAIL event: got kind %0d addr %h data %h cyc %0d expected kind %0d addr %h data %h cyc %0d",
                          k, a, d, c, e.kind, e.addr, e.data, e.at);
        end
    endtask

    // Monitor: every write strobe, restart pulse and rising error flag is an event
    logic err_q = 1'b0;
    always @(negedge CLK) begin
        if (RST_N) begin
            if (imem_we)             mon_pop(EV_WR, imem_addr, imem_wd, cyc);
            if (core_restart)        mon_pop(EV_RS, 32'h0, 32'h0, cyc);
            if (prog_err && !err_q)  mon_pop(EV_ER, 32'h0, 32'h0, cyc);
        end
        err_q = prog_err;
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b;
        @(posedge CLK); #1;
        last_cyc = cyc;
        rx_valid = 1'b0; rx_data = 8'($urandom);
    endtask

    // Build a frame: SYNC, N, data, checksum (length-error frames stop after N)
    task automatic make_frame(input int n, input bit bad);
        logic [7:0] x, b;
        x = 8'h00;
        frm = {};
        frm.push_back(SYNC);
        frm.push_back(8'(n));
        if (n >= 1 && n <= DEPTH) begin
            for (int i = 0; i < 4 * n; i++) begin
                b = 8'($urandom);
                frm.push_back(b);
                x ^= b;
            end
            frm.push_back(bad ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
        end
    endtask

    // Reference model: what a whole frame must produce
    task automatic expect_frame();
        int         n;
        logic [7:0] x;
        logic [31:0] w;
        n = int'(frm[1]);
        m_stall = 1'b1;
        if (n == 0 || n > DEPTH) begin
            push(EV_ER, 32'h0, 32'h0, -1);
            m_err = 1'b1; m_done = 1'b0;
        end else begin
            x = 8'h00;
            for (int i = 0; i < n; i++) begin
                w = {frm[2+4*i+3], frm[2+4*i+2], frm[2+4*i+1], frm[2+4*i]};
                push(EV_WR, 32'(4 * i), w, -1);
                x ^= frm[2+4*i] ^ frm[2+4*i+1] ^ frm[2+4*i+2] ^ frm[2+4*i+3];
            end
            if (frm[2+4*n] == x) begin
                push(EV_RS, 32'h0, 32'h0, -1);
                m_done = 1'b1; m_err = 1'b0; m_stall = 1'b0;
            end else begin
                push(EV_ER, 32'h0, 32'h0, -1);
                m_err = 1'b1; m_done = 1'b0;
            end
        end
    endtask

    task automatic send_frame(input int max_gap);
        expect_frame();
        foreach (frm[i]) begin
            send(frm[i]);
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
    endtask

    task automatic check_status(input string tag);
        idle(4);
        core_pc = $urandom;
        #1;
        chk({tag, "_done"},  32'(prog_done),  32'(m_done));
        chk({tag, "_err"},   32'(prog_err),   32'(m_err));
        chk({tag, "_stall"}, 32'(core_stall), 32'(m_stall));
        chk({tag, "_busy"},  32'(prog_busy),  32'h0);
        chk({tag, "_addr"},  imem_addr,       core_pc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d events pending", exp_q.size());
        $fatal(1);
    end

    initial begin
        // Reset values while RST_N is held low
        core_pc = 32'h0000_1234;
        #1;
        chk("rst_addr", imem_addr, 32'h0000_1234);
        chk("rst_outs", {25'd0, imem_we, core_stall, core_restart, prog_busy, prog_done, prog_err, 1'b0},
            32'h0);
        chk("rst_wd", imem_wd, 32'h0);
        idle(2);
        RST_N = 1'b1;
        idle(1);

        // Idle: address follows the core, non-SYNC bytes do nothing
        for (int i = 0; i < 4; i++) begin
            core_pc = $urandom; #1;
            chk("idle_addr", imem_addr, core_pc);
        end
        for (int i = 0; i < 6; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if (b == SYNC) b = 8'h5A;
            send(b);
        end
        check_status("idle");

        // Known frame: words 0x00000013 and 0x00100093, checksum 13^93^10 = 0x90
        frm = {SYNC, 8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        send_frame(1);
        check_status("known");

        // Length errors
        frm = {SYNC, 8'h00};
        send_frame(0);
        check_status("len0");
        frm = {SYNC, 8'(DEPTH + 1)};
        send_frame(2);
        check_status("len_over");

        // Bad checksum then the good frame again
        frm = {SYNC, 8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h81};
        send_frame(0);
        check_status("badcs");
        frm = {SYNC, 8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        send_frame(0);
        check_status("recover");

        // Timeout inside GET_DATA: error flag rises TMO+1 cycles after the last byte
        send(SYNC); send(8'h01); send(8'h11); send(8'h22);
        push(EV_ER, 32'h0, 32'h0, last_cyc + TMO + 1);
        m_err = 1'b1; m_done = 1'b0; m_stall = 1'b1;
        idle(TMO + 4);
        check_status("timeout");

        // Full-depth frame, bytes every cycle including WRITE cycles
        make_frame(DEPTH, 1'b0);
        send_frame(0);
        check_status("b2b_full");

        // Randomized frames
        for (int f = 0; f < 24; f++) begin
            int r, n;
            r = $urandom_range(0, 9);
            if (r == 0)      n = 0;
            else if (r == 1) n = $urandom_range(DEPTH + 1, 255);
            else             n = $urandom_range(1, DEPTH);
            make_frame(n, $urandom_range(0, 3) == 0);
            send_frame($urandom_range(0, 3));
            check_status("rand");
        end

        // Reset in the middle of GET_DATA: first word already written
        make_frame(3, 1'b0);
        push(EV_WR, 32'h0, {frm[5], frm[4], frm[3], frm[2]}, -1);
        for (int i = 0; i < 8; i++) send(frm[i]);
        idle(1);
        #2;
        RST_N = 1'b0;
        #1;
        m_done = 1'b0; m_err = 1'b0; m_stall = 1'b0;
        chk("midrst_addr", imem_addr, core_pc);
        chk("midrst_outs", {25'd0, imem_we, core_stall, core_restart, prog_busy, prog_done, prog_err, 1'b0},
            32'h0);
        chk("midrst_wd", imem_wd, 32'h0);
        idle(3);
        RST_N = 1'b1;
        idle(1);
        check_status("after_rst");
        make_frame(5, 1'b0);
        send_frame(1);
        check_status("post_rst_frame");

        // Drain any pending expectations
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) idle(1);
        chk("drain_pending", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
